lfu_slot_ctrl: RTL and testbench

Controller for a small fully-associative slot pool using least-frequently-used (LFU) replacement. It accepts tagged requests over a valid/ready handshake and reports hit or miss plus the slot used. On a miss with the pool full, it evicts the least-used slot. Sits between the request-encoding front end and the slot indicators (slot_occupied drives the LEDs).

---
 rtl/lfu_slot_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lfu_slot_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lfu_slot_ctrl.sv
// Fully-associative slot pool controller with least-frequently-used replacement.
// Optional counter aging is enabled by defining LFU_SLOT_CTRL_AGING_EN.
module lfu_slot_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 8,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_W-1:0]     req_tag,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [SLOT_W-1:0]    rsp_slot,
  output logic                 rsp_evicted,
  output logic [TAG_W-1:0]     rsp_evict_tag,
  output logic [NUM_SLOTS-1:0] slot_occupied,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a response holds every rsp_* field until it is taken.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] VICTIM = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tags_q [NUM_SLOTS];
  logic [TAG_W-1:0]     tags_d [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_q  [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_d  [NUM_SLOTS];
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [SLOT_W-1:0]    rsp_slot_q, rsp_slot_d;
  logic                 rsp_evicted_q, rsp_evicted_d;
  logic [TAG_W-1:0]     rsp_evict_tag_q, rsp_evict_tag_d;

  logic                 hit_found, free_found;
  logic [SLOT_W-1:0]    hit_idx, free_idx, victim_idx;
  logic [CNT_W-1:0]     min_cnt;

  // Match, first free slot and LFU victim (strict < keeps ties on the lowest index).
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    victim_idx = '0;
    min_cnt    = cnt_q[0];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_found && valid_q[i] && (tags_q[i] == tag_q)) begin
        hit_found = 1'b1;
        hit_idx   = SLOT_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (cnt_q[i] < min_cnt) begin
        min_cnt    = cnt_q[i];
        victim_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    tag_d           = tag_q;
    valid_d         = valid_q;
    tags_d          = tags_q;
    cnt_d           = cnt_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_hit_d       = rsp_hit_q;
    rsp_slot_d      = rsp_slot_q;
    rsp_evicted_d   = rsp_evicted_q;
    rsp_evict_tag_d = rsp_evict_tag_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d     = '0;
          req_ready_d = 1'b0;
          for (int i = 0; i < NUM_SLOTS; i++) cnt_d[i] = '0;
        end else if (req_valid && req_ready_q) begin
          tag_d       = req_tag;
          req_ready_d = 1'b0;
          state_d     = LOOKUP;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      LOOKUP: begin
        rsp_evicted_d   = 1'b0;
        rsp_evict_tag_d = '0;
        if (hit_found) begin
`ifdef LFU_SLOT_CTRL_AGING_EN
          // Reaching the ceiling halves the whole pool so ratios survive.
          if (cnt_q[hit_idx] == CNT_MAX - CNT_ONE) begin
            for (int i = 0; i < NUM_SLOTS; i++) cnt_d[i] = cnt_q[i] >> 1;
            cnt_d[hit_idx] = CNT_MAX >> 1;
          end else begin
            cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_ONE;
          end
`else
          if (cnt_q[hit_idx] != CNT_MAX) cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_ONE;
`endif
          rsp_hit_d   = 1'b1;
          rsp_slot_d  = hit_idx;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (free_found) begin
          valid_d[free_idx] = 1'b1;
          tags_d[free_idx]  = tag_q;
          cnt_d[free_idx]   = CNT_ONE;
          rsp_hit_d         = 1'b0;
          rsp_slot_d        = free_idx;
          rsp_valid_d       = 1'b1;
          state_d           = RESP;
        end else begin
          state_d = VICTIM;
        end
      end
      VICTIM: begin
        rsp_evicted_d      = 1'b1;
        rsp_evict_tag_d    = tags_q[victim_idx];
        tags_d[victim_idx] = tag_q;
        cnt_d[victim_idx]  = CNT_ONE;
        rsp_hit_d          = 1'b0;
        rsp_slot_d         = victim_idx;
        rsp_valid_d        = 1'b1;
        state_d            = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b0;
      tag_q           <= '0;
      valid_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_slot_q      <= '0;
      rsp_evicted_q   <= 1'b0;
      rsp_evict_tag_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tags_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      tag_q           <= tag_d;
      valid_q         <= valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_slot_q      <= rsp_slot_d;
      rsp_evicted_q   <= rsp_evicted_d;
      rsp_evict_tag_q <= rsp_evict_tag_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tags_q[i] <= tags_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_slot      = rsp_slot_q;
  assign rsp_evicted   = rsp_evicted_q;
  assign rsp_evict_tag = rsp_evict_tag_q;
  assign slot_occupied = valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lfu_slot_ctrl.sv
// Directed bench for lfu_slot_ctrl: fills, hits, LFU eviction, back-pressure,
// flush priority, reset mid-lookup and counter saturation / aging.
module tb_lfu_slot_ctrl;

  localparam int NUM_SLOTS = 4;
  localparam int TAG_W     = 4;
  localparam int CNT_W     = 8;
  localparam int SLOT_W    = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_W-1:0]     req_tag;
  logic                 flush;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [SLOT_W-1:0]    rsp_slot;
  logic                 rsp_evicted;
  logic [TAG_W-1:0]     rsp_evict_tag;
  logic [NUM_SLOTS-1:0] slot_occupied;
  logic [1:0]           dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfu_slot_ctrl #(.NUM_SLOTS(NUM_SLOTS), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_slot(rsp_slot), .rsp_evicted(rsp_evicted), .rsp_evict_tag(rsp_evict_tag),
    .slot_occupied(slot_occupied), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One request; latency counts cycles from the accepting cycle to rsp_valid high.
  // hold > 0 keeps rsp_ready low that many cycles while a second request is offered.
  task automatic do_req(input logic [TAG_W-1:0] tag, input logic exp_hit,
                        input logic [SLOT_W-1:0] exp_slot, input logic exp_ev,
                        input logic [TAG_W-1:0] exp_evtag, input int exp_lat,
                        input logic [NUM_SLOTS-1:0] exp_occ, input int hold);
    int k;
    wait_ready();
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
    chk("rsp_slot", 32'(rsp_slot), 32'(exp_slot));
    chk("rsp_evicted", 32'(rsp_evicted), 32'(exp_ev));
    chk("rsp_evict_tag", 32'(rsp_evict_tag), 32'(exp_evtag));
    chk("slot_occupied", 32'(slot_occupied), 32'(exp_occ));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_tag   = ~tag;
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_hit", 32'(rsp_hit), 32'(exp_hit));
      chk("hold_rsp_slot", 32'(rsp_slot), 32'(exp_slot));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_state", 32'(dbg_state), 32'(S_RESP));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_slot", 32'(rsp_slot), 32'd0);
    chk("rst_rsp_evicted", 32'(rsp_evicted), 32'd0);
    chk("rst_rsp_evict_tag", 32'(rsp_evict_tag), 32'd0);
    chk("rst_occupied", 32'(slot_occupied), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    tick();
    rst = 1'b1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    // Fill the four slots in order.
    do_req(4'd3, 1'b0, 2'd0, 1'b0, 4'd0, 2, 4'b0001, 0);
    do_req(4'd5, 1'b0, 2'd1, 1'b0, 4'd0, 2, 4'b0011, 0);
    do_req(4'd7, 1'b0, 2'd2, 1'b0, 4'd0, 2, 4'b0111, 0);
    do_req(4'd9, 1'b0, 2'd3, 1'b0, 4'd0, 2, 4'b1111, 0);

    // Hits on tag 5; its counter goes to 3.
    do_req(4'd5, 1'b1, 2'd1, 1'b0, 4'd0, 2, 4'b1111, 0);
    do_req(4'd5, 1'b1, 2'd1, 1'b0, 4'd0, 2, 4'b1111, 0);

    // Counters 1,3,1,1: tie at 1 evicts slot 0 (tag 3).
    do_req(4'd11, 1'b0, 2'd0, 1'b1, 4'd3, 3, 4'b1111, 0);

    // Back-pressure on a hit of tag 9 for five cycles.
    do_req(4'd9, 1'b1, 2'd3, 1'b0, 4'd0, 2, 4'b1111, 5);

    // Counters 1,3,1,2: slot 0 (tag 11) is the victim.
    do_req(4'd13, 1'b0, 2'd0, 1'b1, 4'd11, 3, 4'b1111, 0);

    // Flush wins over a simultaneous request.
    wait_ready();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'd5;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_occupied", 32'(slot_occupied), 32'd0);
    chk("flush_state", 32'(dbg_state), 32'(S_IDLE));
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    do_req(4'd5, 1'b0, 2'd0, 1'b0, 4'd0, 2, 4'b0001, 0);

    // Reset while in LOOKUP abandons the request.
    wait_ready();
    req_valid = 1'b1;
    req_tag   = 4'd6;
    tick();
    req_valid = 1'b0;
    chk("lookup_state", 32'(dbg_state), 32'(S_LOOKUP));
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_occupied", 32'(slot_occupied), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    chk("rel_ready_before", 32'(req_ready), 32'd0);
    tick();
    chk("rel_ready_after", 32'(req_ready), 32'd1);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rel_occupied", 32'(slot_occupied), 32'd0);

    // Empty pool again; fill, then hammer slot 0 with 255 hits.
    do_req(4'd5, 1'b0, 2'd0, 1'b0, 4'd0, 2, 4'b0001, 0);
    do_req(4'd1, 1'b0, 2'd1, 1'b0, 4'd0, 2, 4'b0011, 0);
    do_req(4'd2, 1'b0, 2'd2, 1'b0, 4'd0, 2, 4'b0111, 0);
    do_req(4'd3, 1'b0, 2'd3, 1'b0, 4'd0, 2, 4'b1111, 0);
    for (int i = 0; i < 255; i++) begin
      do_req(4'd5, 1'b1, 2'd0, 1'b0, 4'd0, 2, 4'b1111, 0);
    end
    // A wrapped counter would make slot 0 the victim; it must be slot 1.
    do_req(4'd14, 1'b0, 2'd1, 1'b1, 4'd1, 3, 4'b1111, 0);
`ifdef LFU_SLOT_CTRL_AGING_EN
    // Aging zeroed slots 2 and 3, slot 1 was refilled at 1.
    do_req(4'd15, 1'b0, 2'd2, 1'b1, 4'd2, 3, 4'b1111, 0);
`else
    // Counters 255,1,1,1: slot 1 (tag 14) again.
    do_req(4'd15, 1'b0, 2'd1, 1'b1, 4'd14, 3, 4'b1111, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
